// File: rtl/snes_pkg.sv
// snes_pkg: shared types and constants for the SNES controller poll scheduler.
package snes_pkg;

  localparam int SNES_BITS = 16;

  // Serial bit position of each button in the 16-bit controller frame
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_e;

endpackage

// File: rtl/snes_poll_scheduler_if.sv
// snes_poll_scheduler_if: requester handshake, SNES bus pins and frame outputs.
// master = scheduler side, slave = surrounding system / controllers.
interface snes_poll_scheduler_if;

  logic                             enable;
  logic [1:0]                       req;
  logic [1:0]                       ack;
  logic                             busy;
  logic                             snes_latch;
  logic                             snes_clk;
  logic [1:0]                       snes_data;
  logic [snes_pkg::SNES_BITS-1:0]   btn_p0;
  logic [snes_pkg::SNES_BITS-1:0]   btn_p1;
  logic [snes_pkg::SNES_BITS-1:0]   press_p0;
  logic [snes_pkg::SNES_BITS-1:0]   press_p1;
  logic                             frame_valid;
  logic [1:0]                       conn;

  modport master (
    input  enable, req, snes_data,
    output ack, busy, snes_latch, snes_clk,
           btn_p0, btn_p1, press_p0, press_p1, frame_valid, conn
  );

  modport slave (
    output enable, req, snes_data,
    input  ack, busy, snes_latch, snes_clk,
           btn_p0, btn_p1, press_p0, press_p1, frame_valid, conn
  );

endinterface

// File: rtl/snes_data_sync.sv
// snes_data_sync: two-flop synchronizer for one asynchronous controller data line.
module snes_data_sync (
  input  logic clk_25M,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep these as two distinct flops in series.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/snes_poll_scheduler.sv
// snes_poll_scheduler: drives the shared SNES latch/clock bus, serves periodic and on-demand polls.
// Optional build macro: SNES_CONNECT_DETECT_EN (controller-present detection on bits[15:12]).
module snes_poll_scheduler
  import snes_pkg::*;
#(
  parameter int HALF_CLK    = 150,
  parameter int POLL_PERIOD = 416667
) (
  input  logic                  clk_25M,
  input  logic                  rst,
  snes_poll_scheduler_if.master io_bus
);

  localparam int PH_W  = $clog2(2 * HALF_CLK);
  localparam int TMR_W = $clog2(POLL_PERIOD);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * HALF_CLK - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_CLK - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);

  state_e                          r_state;
  state_e                          w_next_state;
  logic                            w_phase_last;
  logic                            w_start;
  logic                            w_done;
  logic [PH_W-1:0]                 r_phase;
  logic [3:0]                      r_bit_idx;
  logic [1:0]                      w_sync;
  logic [1:0][SNES_BITS-1:0]       r_smp;
  logic [1:0][SNES_BITS-1:0]       w_dec;
  logic [1:0][SNES_BITS-1:0]       w_new;
  logic [1:0]                      w_present;
  logic [1:0]                      r_pending;
  logic [1:0]                      r_serving;
  logic                            r_tick_pend;
  logic [TMR_W-1:0]                r_timer;
  logic                            w_wrap;
  logic                            r_snes_latch;
  logic                            r_snes_clk;
  logic [SNES_BITS-1:0]            r_btn_p0;
  logic [SNES_BITS-1:0]            r_btn_p1;
  logic [SNES_BITS-1:0]            r_press_p0;
  logic [SNES_BITS-1:0]            r_press_p1;
  logic                            r_frame_valid;
  logic [1:0]                      r_ack;
  logic [1:0]                      r_conn;

  for (genvar g = 0; g < 2; g++) begin : g_sync
    snes_data_sync u_sync (
      .clk_25M (clk_25M),
      .rst     (rst),
      .i_d     (io_bus.snes_data[g]),
      .o_q     (w_sync[g])
    );
  end

  always_ff @(posedge clk_25M) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_phase_last = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if ((r_pending | io_bus.req) != 2'b00 || r_tick_pend) begin
          w_next_state = ST_LATCH;
          w_start      = 1'b1;
        end
      end
      ST_LATCH: begin
        w_phase_last = (r_phase == LATCH_LAST);
        if (w_phase_last) w_next_state = ST_HIGH;
      end
      ST_HIGH: begin
        w_phase_last = (r_phase == HALF_LAST);
        if (w_phase_last) w_next_state = ST_LOW;
      end
      ST_LOW: begin
        w_phase_last = (r_phase == HALF_LAST);
        if (w_phase_last) w_next_state = (r_bit_idx == 4'd15) ? ST_DONE : ST_HIGH;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign w_done = (r_state == ST_DONE);

  // Phase counter, bit index, serial sampling and registered bus pins
  always_ff @(posedge clk_25M) begin
    if (rst) begin
      r_phase      <= '0;
      r_bit_idx    <= 4'd0;
      r_smp        <= '1;
      r_snes_latch <= 1'b0;
      r_snes_clk   <= 1'b1;
    end else begin
      if (r_state == ST_IDLE || r_state == ST_DONE || w_phase_last) r_phase <= '0;
      else                                                           r_phase <= r_phase + PH_W'(1);

      if (w_start) r_bit_idx <= 4'd0;
      else if (r_state == ST_LOW && w_phase_last && r_bit_idx != 4'd15)
        r_bit_idx <= r_bit_idx + 4'd1;

      if (r_state == ST_HIGH && w_phase_last) begin
        r_smp[0][r_bit_idx] <= w_sync[0];
        r_smp[1][r_bit_idx] <= w_sync[1];
      end

      r_snes_latch <= (w_next_state == ST_LATCH);
      r_snes_clk   <= (w_next_state != ST_LOW);
    end
  end

  assign w_wrap = io_bus.enable && (r_timer == TMR_LAST);

  // A wrap landing on the start edge is kept so that tick is not lost
  always_ff @(posedge clk_25M) begin
    if (rst || !io_bus.enable) begin
      r_timer     <= '0;
      r_tick_pend <= 1'b0;
    end else begin
      r_timer     <= w_wrap ? '0 : r_timer + TMR_W'(1);
      r_tick_pend <= (r_tick_pend & ~w_start) | w_wrap;
    end
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      r_pending <= 2'b00;
      r_serving <= 2'b00;
    end else if (w_start) begin
      r_serving <= r_pending | io_bus.req;
      r_pending <= 2'b00;
    end else begin
      r_pending <= r_pending | io_bus.req;
    end
  end

  always_comb begin
    w_dec     = '0;
    w_new     = '0;
    w_present = 2'b11;
    for (int p = 0; p < 2; p++) begin
      w_dec[p] = ~r_smp[p];
`ifdef SNES_CONNECT_DETECT_EN
      w_present[p] = (w_dec[p][15:12] != 4'hF);
`else
      w_present[p] = 1'b1;
`endif
      w_new[p] = w_present[p] ? w_dec[p] : '0;
    end
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      r_btn_p0      <= '0;
      r_btn_p1      <= '0;
      r_press_p0    <= '0;
      r_press_p1    <= '0;
      r_frame_valid <= 1'b0;
      r_ack         <= 2'b00;
      r_conn        <= 2'b11;
    end else begin
      r_frame_valid <= w_done;
      r_ack         <= w_done ? r_serving : 2'b00;
      if (w_done) begin
        r_btn_p0   <= w_new[0];
        r_btn_p1   <= w_new[1];
        r_press_p0 <= w_new[0] & ~r_btn_p0;
        r_press_p1 <= w_new[1] & ~r_btn_p1;
        r_conn     <= w_present;
      end
    end
  end

  assign io_bus.busy        = (r_state != ST_IDLE);
  assign io_bus.snes_latch  = r_snes_latch;
  assign io_bus.snes_clk    = r_snes_clk;
  assign io_bus.btn_p0      = r_btn_p0;
  assign io_bus.btn_p1      = r_btn_p1;
  assign io_bus.press_p0    = r_press_p0;
  assign io_bus.press_p1    = r_press_p1;
  assign io_bus.frame_valid = r_frame_valid;
  assign io_bus.ack         = r_ack;
  assign io_bus.conn        = r_conn;

endmodule
